// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter in front of an FPro MMIO bus: IDLE -> BUS -> ACK per transaction.
// Define MMIO_ARB_LOCK_EN to let a locked master chain transactions without re-arbitration.
`timescale 1ns/1ps

module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // master 0
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    // master 1
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    // MMIO controller side
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_ACK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_id;        // master owning the current transaction
    logic              r_prio;      // master that wins a tie
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_data0;
    logic [DATA_W-1:0] r_rd_data1;

    logic w_valid0;
    logic w_valid1;
    logic w_win_id;
    logic w_load;
    logic w_load_id;
    logic w_sel_wr;
    logic w_bus;
    logic w_own;

    assign w_valid0 = m0_req & (m0_wr | m0_rd);
    assign w_valid1 = m1_req & (m1_wr | m1_rd);
    assign w_win_id = (w_valid0 & w_valid1) ? r_prio : w_valid1;

`ifdef MMIO_ARB_LOCK_EN
    logic w_lock_keep;
    assign w_lock_keep = r_id ? (m1_lock & w_valid1) : (m0_lock & w_valid0);
`else
    logic w_unused_lock;
    assign w_unused_lock = m0_lock | m1_lock;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_id   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid0 | w_valid1) begin
                    w_state_nxt = ST_BUS;
                    w_load      = 1'b1;
                    w_load_id   = w_win_id;
                end
            end
            ST_BUS: w_state_nxt = ST_ACK;
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
`ifdef MMIO_ARB_LOCK_EN
                if (w_lock_keep) begin
                    w_state_nxt = ST_BUS;
                    w_load      = 1'b1;
                    w_load_id   = r_id;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_sel_wr = w_load_id ? m1_wr : m0_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id       <= 1'b0;
            r_prio     <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_rd_data0 <= '0;
            r_rd_data1 <= '0;
        end else begin
            if (w_load) begin
                r_id      <= w_load_id;
                r_prio    <= ~w_load_id;
                r_wr      <= w_sel_wr;
                r_rd      <= ~w_sel_wr;     // write wins when both wr and rd are set
                r_addr    <= w_load_id ? m1_addr : m0_addr;
                r_wr_data <= w_load_id ? m1_wr_data : m0_wr_data;
            end
            if (r_state == ST_BUS && r_rd) begin
                if (r_id) r_rd_data1 <= mmio_rd_data;
                else      r_rd_data0 <= mmio_rd_data;
            end
        end
    end

    // Bus and handshake outputs decode registered state only; reset clears them at once.
    assign w_bus = (r_state == ST_BUS);
    assign w_own = (r_state == ST_BUS) || (r_state == ST_ACK);

    assign mmio_cs      = w_bus;
    assign mmio_wr      = w_bus & r_wr;
    assign mmio_rd      = w_bus & r_rd;
    assign mmio_addr    = w_bus ? r_addr : '0;
    assign mmio_wr_data = w_bus ? r_wr_data : '0;

    assign m0_gnt     = w_own & ~r_id;
    assign m1_gnt     = w_own & r_id;
    assign m0_ack     = (r_state == ST_ACK) & ~r_id;
    assign m1_ack     = (r_state == ST_ACK) & r_id;
    assign m0_rd_data = r_rd_data0;
    assign m1_rd_data = r_rd_data1;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: directed steps push expected bus strobes and acks,
// monitors pop and compare them on the falling edge. Honours MMIO_ARB_LOCK_EN like the DUT.
`timescale 1ns/1ps

module tb_mmio_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              m0_req, m0_wr, m0_rd, m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_gnt, m0_ack;
    logic [DATA_W-1:0] m0_rd_data;
    logic              m1_req, m1_wr, m1_rd, m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_gnt, m1_ack;
    logic [DATA_W-1:0] m1_rd_data;
    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;
    logic [DATA_W-1:0] bus_rd_val;

    assign mmio_rd_data = bus_rd_val;

    always #5 clk = ~clk;

    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
    );

    typedef struct {
        logic              id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
        int                spacing;   // expected cycles since previous ack, 0 = unchecked
    } ack_exp_t;

    bus_exp_t          bus_q[$];
    ack_exp_t          ack_q[$];
    bus_exp_t          mon_b;
    ack_exp_t          mon_a;
    logic [DATA_W-1:0] exp_rd [2];
    int                n_cmp        = 0;
    int                n_bad        = 0;
    int                cyc          = 0;
    int                bus_count    = 0;
    int                last_ack_cyc = -1;
    int                base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic id, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input int spacing);
        bus_exp_t b;
        ack_exp_t a;
        b.id = id; b.wr = wr; b.addr = addr; b.wdata = wdata;
        bus_q.push_back(b);
        if (!wr) exp_rd[id] = bus_rd_val;
        a.id = id; a.rd0 = exp_rd[0]; a.rd1 = exp_rd[1]; a.spacing = spacing;
        ack_q.push_back(a);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && (bus_q.size() != 0 || ack_q.size() != 0); i++)
            @(posedge clk);
        check("drain_bus_q", bus_q.size(), 0);
        check("drain_ack_q", ack_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_bus(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (bus_count >= target) break;
        end
        check("wait_bus_reached", (bus_count >= target), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: bus strobes and acks are matched in order against the scoreboard.
    always @(negedge clk) begin
        check("gnt_onehot0", $onehot0({m1_gnt, m0_gnt}), 1);
        if (mmio_cs === 1'b1) begin
            bus_count++;
            if (bus_q.size() == 0) begin
                check("bus_unexpected_cs", mmio_cs, 0);
            end else begin
                mon_b = bus_q.pop_front();
                check("bus_wr", mmio_wr, mon_b.wr);
                check("bus_rd", mmio_rd, !mon_b.wr);
                check("bus_addr", mmio_addr, mon_b.addr);
                check("bus_wdata", mmio_wr_data, mon_b.wdata);
                check("bus_gnt", {m1_gnt, m0_gnt}, mon_b.id ? 2'b10 : 2'b01);
            end
        end else begin
            check("bus_idle_zero", {mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 0);
        end
        if ((m0_ack | m1_ack) === 1'b1) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", {m1_ack, m0_ack}, 0);
            end else begin
                mon_a = ack_q.pop_front();
                check("ack_vec", {m1_ack, m0_ack}, mon_a.id ? 2'b10 : 2'b01);
                check("ack_gnt", {m1_gnt, m0_gnt}, mon_a.id ? 2'b10 : 2'b01);
                check("ack_rd0", m0_rd_data, mon_a.rd0);
                check("ack_rd1", m1_rd_data, mon_a.rd1);
                if (mon_a.spacing != 0 && last_ack_cyc >= 0)
                    check("ack_spacing", cyc - last_ack_cyc, mon_a.spacing);
            end
            last_ack_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m0_req = 0; m0_wr = 0; m0_rd = 0; m0_lock = 0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 0; m1_wr = 0; m1_rd = 0; m1_lock = 0; m1_addr = '0; m1_wr_data = '0;
        bus_rd_val = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        #2 reset = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {m1_gnt, m0_gnt}, 0);
        check("rst_ack", {m1_ack, m0_ack}, 0);
        check("rst_cs", mmio_cs, 0);
        check("rst_rd0", m0_rd_data, 0);
        check("rst_rd1", m1_rd_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // m0 write, fixed latency, fields changed after grant
        @(posedge clk); #1;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00400; m0_wr_data = 32'hA5;
        expect_txn(1'b0, 1'b1, 21'h00400, 32'hA5, 0);
        @(posedge clk); #1;
        check("lat_cs_n1", mmio_cs, 1);
        m0_req = 0; m0_wr = 0; m0_addr = '1; m0_wr_data = '1;
        @(posedge clk); #1;
        check("lat_ack_n2", m0_ack, 1);
        drain(20);

        // m1 read; bus data changes right after capture edge
        bus_rd_val = 32'h12345678;
        @(posedge clk); #1;
        m1_req = 1; m1_rd = 1; m1_addr = 21'h00C00; m1_wr_data = '0;
        expect_txn(1'b1, 1'b0, 21'h00C00, 32'h0, 0);
        @(posedge clk); #1;
        m1_req = 0; m1_rd = 0;
        @(posedge clk); #1;
        check("rd_n2_m1", m1_rd_data, 32'h12345678);
        bus_rd_val = 32'hBAD0BAD0;
        drain(20);

        // Both masters continuously: alternation, one ack per 3 cycles
        bus_rd_val = 32'hCAFEF00D;
        expect_txn(1'b0, 1'b1, 21'h00010, 32'h1111, 0);
        expect_txn(1'b1, 1'b0, 21'h00020, 32'h0, 3);
        expect_txn(1'b0, 1'b1, 21'h00010, 32'h1111, 3);
        expect_txn(1'b1, 1'b0, 21'h00020, 32'h0, 3);
        base = bus_count;
        @(posedge clk); #1;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00010; m0_wr_data = 32'h1111;
        m1_req = 1; m1_rd = 1; m1_addr = 21'h00020; m1_wr_data = '0;
        wait_bus(base + 4, 40);
        m0_req = 0; m0_wr = 0; m1_req = 0; m1_rd = 0;
        drain(20);

        // wr and rd together -> write; no type -> no grant
        @(posedge clk); #1;
        m0_req = 1; m0_wr = 1; m0_rd = 1; m0_addr = 21'h00030; m0_wr_data = 32'h77;
        expect_txn(1'b0, 1'b1, 21'h00030, 32'h77, 0);
        @(posedge clk); #1;
        m0_req = 0; m0_wr = 0; m0_rd = 0;
        drain(20);
        m0_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("novalid_gnt", {m1_gnt, m0_gnt}, 0);
        end
        m0_req = 0;

        // Reset during BUS aborts; priority returns to m0
        @(posedge clk); #1;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00040; m0_wr_data = 32'h55;
        expect_txn(1'b0, 1'b1, 21'h00040, 32'h55, 0);
        @(posedge clk); #1;
        m0_req = 0; m0_wr = 0;
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_cs", mmio_cs, 0);
        check("abort_gnt", {m1_gnt, m0_gnt}, 0);
        check("abort_rd0", m0_rd_data, 0);
        void'(ack_q.pop_back());
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00050; m0_wr_data = 32'h66;
        m1_req = 1; m1_wr = 1; m1_addr = 21'h00060; m1_wr_data = 32'h88;
        repeat (2) @(posedge clk);
        #1;
        check("inrst_gnt", {m1_gnt, m0_gnt}, 0);
        check("inrst_ack", {m1_ack, m0_ack}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_no_early_gnt", {m1_gnt, m0_gnt}, 0);
        expect_txn(1'b0, 1'b1, 21'h00050, 32'h66, 0);
        base = bus_count;
        wait_bus(base + 1, 10);
        m0_req = 0; m0_wr = 0; m1_req = 0; m1_wr = 0;
        drain(20);

        // m1 locked for 3 reads while m0 requests
        bus_rd_val = 32'h0BADF00D;
`ifdef MMIO_ARB_LOCK_EN
        expect_txn(1'b1, 1'b0, 21'h00070, 32'h0, 0);
        expect_txn(1'b1, 1'b0, 21'h00070, 32'h0, 2);
        expect_txn(1'b1, 1'b0, 21'h00070, 32'h0, 2);
        expect_txn(1'b0, 1'b1, 21'h00080, 32'h99, 3);
`else
        expect_txn(1'b1, 1'b0, 21'h00070, 32'h0, 0);
        expect_txn(1'b0, 1'b1, 21'h00080, 32'h99, 3);
        expect_txn(1'b1, 1'b0, 21'h00070, 32'h0, 3);
        expect_txn(1'b0, 1'b1, 21'h00080, 32'h99, 3);
`endif
        base = bus_count;
        @(posedge clk); #1;
        m1_req = 1; m1_rd = 1; m1_lock = 1; m1_addr = 21'h00070; m1_wr_data = '0;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00080; m0_wr_data = 32'h99;
        wait_bus(base + 3, 30);
        m1_lock = 0;
        wait_bus(base + 4, 30);
        m0_req = 0; m0_wr = 0; m1_req = 0; m1_rd = 0;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
